// File: rtl/instr_pkg.sv
// Instruction / response formats and the accept-time address range check.
package instr_pkg;

    import nmcu_pkg::*;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_LOAD  = 4'd1,
        OP_STORE = 4'd2,
        OP_MAC   = 4'd3
    } opcode_t;

    typedef struct packed {
        opcode_t               opcode;
        logic [ADDR_WIDTH-1:0] addr_a;
        logic [ADDR_WIDTH-1:0] addr_b;
        logic [ADDR_WIDTH-1:0] addr_c;
        logic [DATA_WIDTH-1:0] data;
        logic [LEN_WIDTH-1:0]  len;
    } instruction_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            status;
    } nmcu_cpu_resp_t;

    localparam logic [1:0] STATUS_OK         = 2'b00;
    localparam logic [1:0] STATUS_ERR_ADDR   = 2'b01;
    localparam logic [1:0] STATUS_ERR_OPCODE = 2'b10;

    // True when any address the instruction would touch lies outside memory.
    // A zero-length MAC reads nothing, so only its destination is checked.
    function automatic logic addrOutOfRange(
        input opcode_t               opcode,
        input logic [ADDR_WIDTH-1:0] addrA,
        input logic [ADDR_WIDTH-1:0] addrB,
        input logic [ADDR_WIDTH-1:0] addrC,
        input logic [LEN_WIDTH-1:0]  len
    );
        logic [XW-1:0] limit;
        logic [XW-1:0] endA;
        logic [XW-1:0] endB;
        limit = XW'(MEM_DEPTH);
        endA  = XW'(addrA) + XW'(len) - XW'(1);
        endB  = XW'(addrB) + XW'(len) - XW'(1);
        case (opcode)
            OP_LOAD, OP_STORE: addrOutOfRange = (XW'(addrA) >= limit);
            OP_MAC:            addrOutOfRange = (XW'(addrC) >= limit) ||
                                                ((len != '0) && ((endA >= limit) || (endB >= limit)));
            default:           addrOutOfRange = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/nmcu_pkg.sv
// Global sizing parameters for the near-memory compute unit.
package nmcu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 16;
    localparam int LEN_WIDTH  = 8;
    localparam int MEM_DEPTH  = 1024;
    localparam int MEM_AW     = $clog2(MEM_DEPTH);

    // Wide enough to hold addr + len - 1 without overflow.
    localparam int XW = ADDR_WIDTH + 2;

endpackage

// File: rtl/nmcu_mem_array.sv
// Private data memory: two combinational read ports and one synchronous
// write port. Out-of-range reads return zero and out-of-range writes are dropped.
module nmcu_mem_array
    import nmcu_pkg::*;
(
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] i_rdAddrA,
    output logic [DATA_WIDTH-1:0] o_rdDataA,
    input  logic [ADDR_WIDTH-1:0] i_rdAddrB,
    output logic [DATA_WIDTH-1:0] o_rdDataB,
    input  logic                  i_wrEn,
    input  logic [ADDR_WIDTH-1:0] i_wrAddr,
    input  logic [DATA_WIDTH-1:0] i_wrData
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    assign o_rdDataA = (i_rdAddrA < ADDR_WIDTH'(MEM_DEPTH)) ? r_mem[i_rdAddrA[MEM_AW-1:0]] : '0;
    assign o_rdDataB = (i_rdAddrB < ADDR_WIDTH'(MEM_DEPTH)) ? r_mem[i_rdAddrB[MEM_AW-1:0]] : '0;

    // Single write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_wrEn && (i_wrAddr < ADDR_WIDTH'(MEM_DEPTH))) begin
            r_mem[i_wrAddr[MEM_AW-1:0]] <= i_wrData;
        end
    end

endmodule

// File: rtl/nmcu.sv
// Near-memory compute unit: one instruction at a time, executed against the
// private memory, with exactly one registered response per instruction.
module nmcu
    import nmcu_pkg::*;
    import instr_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           cpu_instr_valid,
    input  instruction_t   cpu_instruction,
    output logic           cpu_instr_ready,
    output logic           nmcu_resp_valid_o,
    input  logic           nmcu_resp_ready_i,
    output nmcu_cpu_resp_t nmcu_response_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB,
        S_RESP
    } state_t;

    state_t                r_state;
    instruction_t          r_instr;
    logic [1:0]            r_status;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [LEN_WIDTH-1:0]  r_idx;
    logic                  r_respValid;
    logic [DATA_WIDTH-1:0] r_respData;
    logic [1:0]            r_respStatus;

    logic [ADDR_WIDTH-1:0] w_rdAddrA;
    logic [ADDR_WIDTH-1:0] w_rdAddrB;
    logic [DATA_WIDTH-1:0] w_rdDataA;
    logic [DATA_WIDTH-1:0] w_rdDataB;
    logic [DATA_WIDTH-1:0] w_macSum;
    logic                  w_wrEn;
    logic [ADDR_WIDTH-1:0] w_wrAddr;
    logic [DATA_WIDTH-1:0] w_wrData;
    logic [1:0]            w_acceptStatus;

    assign cpu_instr_ready   = (r_state == S_IDLE) && !rst;
    assign nmcu_resp_valid_o = r_respValid;
    assign nmcu_response_o   = '{data: r_respData, status: r_respStatus};

    // The read ports walk both operand vectors; a LOAD simply sees index 0.
    assign w_rdAddrA = r_instr.addr_a + ADDR_WIDTH'(r_idx);
    assign w_rdAddrB = r_instr.addr_b + ADDR_WIDTH'(r_idx);

    // Only the low DATA_WIDTH bits of each product survive the modular accumulate.
    assign w_macSum = r_acc + w_rdDataA * w_rdDataB;

    nmcu_mem_array u_mem (
        .clk       (clk),
        .i_rdAddrA (w_rdAddrA),
        .o_rdDataA (w_rdDataA),
        .i_rdAddrB (w_rdAddrB),
        .o_rdDataB (w_rdDataB),
        .i_wrEn    (w_wrEn),
        .i_wrAddr  (w_wrAddr),
        .i_wrData  (w_wrData)
    );

    // Classify the offered instruction so errors are known before execution.
    always_comb begin
        w_acceptStatus = STATUS_OK;
        if (!(cpu_instruction.opcode inside {OP_NOP, OP_LOAD, OP_STORE, OP_MAC})) begin
            w_acceptStatus = STATUS_ERR_OPCODE;
        end else if (addrOutOfRange(cpu_instruction.opcode, cpu_instruction.addr_a,
                                    cpu_instruction.addr_b, cpu_instruction.addr_c,
                                    cpu_instruction.len)) begin
            w_acceptStatus = STATUS_ERR_ADDR;
        end
    end

    // Memory write port: STORE and zero-length MAC write in EXEC, MAC writes back in WB.
    always_comb begin
        w_wrEn   = 1'b0;
        w_wrAddr = r_instr.addr_a;
        w_wrData = r_instr.data;
        if (!rst && (r_status == STATUS_OK)) begin
            if ((r_state == S_EXEC) && (r_instr.opcode == OP_STORE)) begin
                w_wrEn = 1'b1;
            end else if ((r_state == S_EXEC) && (r_instr.opcode == OP_MAC) && (r_instr.len == '0)) begin
                w_wrEn   = 1'b1;
                w_wrAddr = r_instr.addr_c;
                w_wrData = '0;
            end else if (r_state == S_WB) begin
                w_wrEn   = 1'b1;
                w_wrAddr = r_instr.addr_c;
                w_wrData = r_acc;
            end
        end
    end

    // Control FSM with the MAC datapath and the registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_instr      <= '0;
            r_status     <= STATUS_OK;
            r_acc        <= '0;
            r_idx        <= '0;
            r_respValid  <= 1'b0;
            r_respData   <= '0;
            r_respStatus <= STATUS_OK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_instr_valid) begin
                        r_instr  <= cpu_instruction;
                        r_status <= w_acceptStatus;
                        r_acc    <= '0;
                        r_idx    <= '0;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_status != STATUS_OK) begin
                        r_respData   <= '0;
                        r_respStatus <= r_status;
                        r_state      <= S_RESP;
                    end else if (r_instr.opcode == OP_LOAD) begin
                        r_respData   <= w_rdDataA;
                        r_respStatus <= STATUS_OK;
                        r_state      <= S_RESP;
                    end else if ((r_instr.opcode == OP_MAC) && (r_instr.len != '0)) begin
                        r_acc <= w_macSum;
                        if (r_idx == r_instr.len - LEN_WIDTH'(1)) begin
                            r_state <= S_WB;
                        end else begin
                            r_idx <= r_idx + LEN_WIDTH'(1);
                        end
                    end else begin
                        r_respData   <= '0;
                        r_respStatus <= STATUS_OK;
                        r_state      <= S_RESP;
                    end
                end
                S_WB: begin
                    r_respData   <= r_acc;
                    r_respStatus <= STATUS_OK;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (!r_respValid) begin
                        r_respValid <= 1'b1;
                    end else if (nmcu_resp_ready_i) begin
                        r_respValid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nmcu.sv
// Self-checking bench for nmcu: directed scenarios plus randomized traffic
// compared against an instruction-level memory model.
module tb_nmcu;

   import nmcu_pkg::*;
   import instr_pkg::*;

   logic           clk = 1'b0;
   logic           rst;
   logic           cpu_instr_valid;
   instruction_t   cpu_instruction;
   logic           cpu_instr_ready;
   logic           nmcu_resp_valid_o;
   logic           nmcu_resp_ready_i;
   nmcu_cpu_resp_t nmcu_response_o;

   int checks = 0;
   int errors = 0;

   logic [31:0] modelMem [MEM_DEPTH];

   nmcu dut (
      .clk               (clk),
      .rst               (rst),
      .cpu_instr_valid   (cpu_instr_valid),
      .cpu_instruction   (cpu_instruction),
      .cpu_instr_ready   (cpu_instr_ready),
      .nmcu_resp_valid_o (nmcu_resp_valid_o),
      .nmcu_resp_ready_i (nmcu_resp_ready_i),
      .nmcu_response_o   (nmcu_response_o)
   );

   always #5 clk = ~clk;

   // Hard stop in case the DUT wedges somewhere the bounded waits miss.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic instruction_t mkInstr(input logic [3:0] op, input int a, input int b,
                                            input int c, input logic [31:0] d, input int n);
      instruction_t t;
      t.opcode = opcode_t'(op);
      t.addr_a = 16'(a);
      t.addr_b = 16'(b);
      t.addr_c = 16'(c);
      t.data   = d;
      t.len    = 8'(n);
      return t;
   endfunction

   // Instruction-level reference: expected response and latency, memory updated.
   function automatic void modelExec(input instruction_t ins, output logic [31:0] expData,
                                     output logic [1:0] expStatus, output int expLat);
      int op;
      int a;
      int b;
      int c;
      int n;
      logic [63:0] acc;
      logic [63:0] x;
      logic [63:0] y;
      op = int'(ins.opcode);
      a  = int'(ins.addr_a);
      b  = int'(ins.addr_b);
      c  = int'(ins.addr_c);
      n  = int'(ins.len);
      expData   = 32'd0;
      expStatus = 2'd0;
      expLat    = 2;
      if (op > 3) begin
         expStatus = 2'd2;
      end else if ((op == 1 || op == 2) && a >= MEM_DEPTH) begin
         expStatus = 2'd1;
      end else if (op == 3 && (c >= MEM_DEPTH || (n > 0 && (a + n - 1 >= MEM_DEPTH || b + n - 1 >= MEM_DEPTH)))) begin
         expStatus = 2'd1;
      end else if (op == 1) begin
         expData = modelMem[a];
      end else if (op == 2) begin
         modelMem[a] = ins.data;
      end else if (op == 3) begin
         acc = 64'd0;
         for (int i = 0; i < n; i++) begin
            x   = {32'd0, modelMem[a + i]};
            y   = {32'd0, modelMem[b + i]};
            acc = acc + x * y;
         end
         modelMem[c] = acc[31:0];
         expData     = acc[31:0];
         if (n > 0) expLat = n + 2;
      end
   endfunction

   // Drives one instruction and collects its response; lat = -1 on timeout.
   task automatic doOp(input instruction_t ins, output logic [31:0] data,
                       output logic [1:0] status, output int lat);
      int w;
      data   = 32'd0;
      status = 2'b11;
      lat    = -1;
      cpu_instruction = ins;
      cpu_instr_valid = 1'b1;
      w = 0;
      while (!cpu_instr_ready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      if (!cpu_instr_ready) begin
         cpu_instr_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      cpu_instr_valid = 1'b0;
      w = 0;
      while (!nmcu_resp_valid_o && w < 300) begin
         @(posedge clk); #1;
         w++;
      end
      if (!nmcu_resp_valid_o) return;
      lat    = w;
      data   = nmcu_response_o.data;
      status = nmcu_response_o.status;
      @(posedge clk); #1;
   endtask

   task automatic applyStimulus(input instruction_t ins, output logic [31:0] d, output logic [1:0] s,
                                output int l, output logic [31:0] ed, output logic [1:0] es, output int el);
      doOp(ins, d, s, l);
      modelExec(ins, ed, es, el);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cpu_instr_valid = 1'b0;
      cpu_instruction = '0;
      nmcu_resp_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (cpu_instr_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b want 0", cpu_instr_ready); end
      checks++;
      if (nmcu_resp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", nmcu_resp_valid_o); end
      checks++;
      if (nmcu_response_o !== '0) begin errors++; $display("[TB] FAIL reset_resp got %h want 0", nmcu_response_o); end
      rst = 1'b0;
      #1;
      checks++;
      if (cpu_instr_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready got %b want 1", cpu_instr_ready); end
   endtask

   task automatic test_store_load();
      instruction_t prog [4];
      logic [31:0] d, ed;
      logic [1:0] s, es;
      int l, el;
      prog[0] = mkInstr(4'd2, 100, 0, 0, 32'd55, 0);
      prog[1] = mkInstr(4'd2, 101, 0, 0, 32'd2, 0);
      prog[2] = mkInstr(4'd1, 100, 0, 0, 32'd0, 0);
      prog[3] = mkInstr(4'd1, 101, 0, 0, 32'd0, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(prog[i], d, s, l, ed, es, el);
         checks++;
         if ({d, s} !== {ed, es}) begin errors++; $display("[TB] FAIL store_load[%0d] got %0d/%0d want %0d/%0d", i, d, s, ed, es); end
         checks++;
         if (l !== el) begin errors++; $display("[TB] FAIL store_load_lat[%0d] got %0d want %0d", i, l, el); end
      end
   endtask

   task automatic test_mac();
      logic [31:0] d, ed;
      logic [1:0] s, es;
      int l, el;
      applyStimulus(mkInstr(4'd3, 100, 101, 200, 32'd0, 1), d, s, l, ed, es, el);
      checks++;
      if ({d, s} !== {32'd110, 2'd0}) begin errors++; $display("[TB] FAIL mac_len1 got %0d/%0d want 110/0", d, s); end
      checks++;
      if (l !== 3) begin errors++; $display("[TB] FAIL mac_len1_lat got %0d want 3", l); end
      applyStimulus(mkInstr(4'd1, 200, 0, 0, 32'd0, 0), d, s, l, ed, es, el);
      checks++;
      if ({d, s} !== {32'd110, 2'd0}) begin errors++; $display("[TB] FAIL load_mac_len1 got %0d/%0d want 110/0", d, s); end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(mkInstr(4'd2, 110 + i, 0, 0, 32'(i + 1), 0), d, s, l, ed, es, el);
         applyStimulus(mkInstr(4'd2, 120 + i, 0, 0, 32'(i + 4), 0), d, s, l, ed, es, el);
      end
      applyStimulus(mkInstr(4'd3, 110, 120, 210, 32'd0, 3), d, s, l, ed, es, el);
      checks++;
      if ({d, s} !== {32'd32, 2'd0}) begin errors++; $display("[TB] FAIL mac_len3 got %0d/%0d want 32/0", d, s); end
      checks++;
      if (l !== 5) begin errors++; $display("[TB] FAIL mac_len3_lat got %0d want 5", l); end
      applyStimulus(mkInstr(4'd1, 210, 0, 0, 32'd0, 0), d, s, l, ed, es, el);
      checks++;
      if (d !== 32'd32) begin errors++; $display("[TB] FAIL load_mac_len3 got %0d want 32", d); end
      applyStimulus(mkInstr(4'd2, 211, 0, 0, 32'd99, 0), d, s, l, ed, es, el);
      applyStimulus(mkInstr(4'd3, 110, 120, 211, 32'd0, 0), d, s, l, ed, es, el);
      checks++;
      if ({d, s} !== {32'd0, 2'd0}) begin errors++; $display("[TB] FAIL mac_len0 got %0d/%0d want 0/0", d, s); end
      checks++;
      if (l !== 2) begin errors++; $display("[TB] FAIL mac_len0_lat got %0d want 2", l); end
      applyStimulus(mkInstr(4'd1, 211, 0, 0, 32'd0, 0), d, s, l, ed, es, el);
      checks++;
      if (d !== 32'd0) begin errors++; $display("[TB] FAIL load_mac_len0 got %0d want 0", d); end
   endtask

   task automatic test_back_to_back_backpressure();
      instruction_t ld;
      nmcu_cpu_resp_t held;
      logic [31:0] d, ed;
      logic [1:0] s, es;
      int l, el;
      int w;
      ld = mkInstr(4'd1, 100, 0, 0, 32'd0, 0);
      modelExec(ld, ed, es, el);
      nmcu_resp_ready_i = 1'b0;
      cpu_instruction = ld;
      cpu_instr_valid = 1'b1;
      @(posedge clk); #1;
      cpu_instr_valid = 1'b0;
      w = 0;
      while (!nmcu_resp_valid_o && w < 20) begin @(posedge clk); #1; w++; end
      held = nmcu_response_o;
      checks++;
      if ({nmcu_resp_valid_o, held} !== {1'b1, ed, es}) begin
         errors++; $display("[TB] FAIL stall_first got v=%b %h want v=1 %h", nmcu_resp_valid_o, held, {ed, es});
      end
      cpu_instruction = mkInstr(4'd2, 100, 0, 0, 32'd999, 0);
      cpu_instr_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({nmcu_resp_valid_o, nmcu_response_o} !== {1'b1, held}) begin
            errors++; $display("[TB] FAIL stall_hold[%0d] got v=%b %h want v=1 %h", i, nmcu_resp_valid_o, nmcu_response_o, held);
         end
         checks++;
         if (cpu_instr_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready[%0d] got %b want 0", i, cpu_instr_ready); end
      end
      cpu_instr_valid = 1'b0;
      nmcu_resp_ready_i = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({nmcu_resp_valid_o, cpu_instr_ready} !== 2'b01) begin
         errors++; $display("[TB] FAIL release got valid=%b ready=%b want 0/1", nmcu_resp_valid_o, cpu_instr_ready);
      end
      applyStimulus(ld, d, s, l, ed, es, el);
      checks++;
      if (d !== 32'd55) begin errors++; $display("[TB] FAIL ignored_store got %0d want 55", d); end
   endtask

   task automatic test_errors();
      instruction_t prog [10];
      logic [31:0] d, ed;
      logic [1:0] s, es;
      int l, el;
      for (int i = 0; i < 4; i++) prog[i] = mkInstr(4'd2, 1020 + i, 0, 0, $urandom, 0);
      prog[4] = mkInstr(4'd3, 1020, 1020, 1023, 32'd0, 4);
      prog[5] = mkInstr(4'd3, 1020, 1020, 100, 32'd0, 5);
      prog[6] = mkInstr(4'd1, 1024, 0, 0, 32'd0, 0);
      prog[7] = mkInstr(4'd7, 100, 0, 0, 32'd12345, 0);
      prog[8] = mkInstr(4'd3, 100, 100, 1024, 32'd0, 0);
      prog[9] = mkInstr(4'd1, 100, 0, 0, 32'd0, 0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(prog[i], d, s, l, ed, es, el);
         checks++;
         if ({d, s} !== {ed, es}) begin errors++; $display("[TB] FAIL errors[%0d] got %0d/%0d want %0d/%0d", i, d, s, ed, es); end
         checks++;
         if (l !== el) begin errors++; $display("[TB] FAIL errors_lat[%0d] got %0d want %0d", i, l, el); end
      end
      checks++;
      if ({d, s} !== {32'd55, 2'd0}) begin errors++; $display("[TB] FAIL mem_unchanged got %0d/%0d want 55/0", d, s); end
   endtask

   task automatic test_reset_mid_mac();
      logic [31:0] d, ed;
      logic [1:0] s, es;
      int l, el;
      bit sawValid;
      for (int i = 0; i < 10; i++) applyStimulus(mkInstr(4'd2, 400 + i, 0, 0, $urandom, 0), d, s, l, ed, es, el);
      applyStimulus(mkInstr(4'd2, 420, 0, 0, 32'd77, 0), d, s, l, ed, es, el);
      cpu_instruction = mkInstr(4'd3, 400, 400, 420, 32'd0, 10);
      cpu_instr_valid = 1'b1;
      @(posedge clk); #1;
      cpu_instr_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      sawValid = 1'b0;
      repeat (12) begin
         if (nmcu_resp_valid_o) sawValid = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (sawValid !== 1'b0) begin errors++; $display("[TB] FAIL abort_resp got valid=1 want 0"); end
      checks++;
      if (cpu_instr_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready got %b want 1", cpu_instr_ready); end
      applyStimulus(mkInstr(4'd1, 420, 0, 0, 32'd0, 0), d, s, l, ed, es, el);
      checks++;
      if ({d, s} !== {32'd77, 2'd0}) begin errors++; $display("[TB] FAIL abort_addr_c got %0d/%0d want 77/0", d, s); end
   endtask

   task automatic test_random();
      instruction_t ins;
      logic [31:0] d, ed;
      logic [1:0] s, es;
      int l, el;
      int r;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(mkInstr(4'd2, 300 + i, 0, 0, $urandom, 0), d, s, l, ed, es, el);
         checks++;
         if ({d, s} !== {ed, es}) begin errors++; $display("[TB] FAIL rnd_init[%0d] got %0d/%0d want %0d/%0d", i, d, s, ed, es); end
      end
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         if (r <= 2)      ins = mkInstr(4'd1, 300 + $urandom_range(0, 15), 0, 0, 32'd0, 0);
         else if (r <= 4) ins = mkInstr(4'd2, 300 + $urandom_range(0, 15), 0, 0, $urandom, 0);
         else if (r <= 7) ins = mkInstr(4'd3, 300 + $urandom_range(0, 11), 300 + $urandom_range(0, 11),
                                        300 + $urandom_range(0, 15), 32'd0, $urandom_range(0, 4));
         else if (r == 8) ins = mkInstr(4'd0, 0, 0, 0, $urandom, 0);
         else if ($urandom_range(0, 1) == 0) ins = mkInstr(4'($urandom_range(4, 15)), 300, 300, 300, $urandom, 1);
         else             ins = mkInstr(4'd1, 1024 + $urandom_range(0, 2000), 0, 0, 32'd0, 0);
         applyStimulus(ins, d, s, l, ed, es, el);
         checks++;
         if ({d, s} !== {ed, es}) begin errors++; $display("[TB] FAIL rnd[%0d] op=%0d got %h/%0d want %h/%0d", i, ins.opcode, d, s, ed, es); end
         checks++;
         if (l !== el) begin errors++; $display("[TB] FAIL rnd_lat[%0d] op=%0d got %0d want %0d", i, ins.opcode, l, el); end
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_mac();
      test_back_to_back_backpressure();
      test_errors();
      test_reset_mid_mac();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
